merger: RTL and testbench
=========================

MERGER -- requirements
Module: merger

Interface
REQ-001 SHALL have parameter PORTS_N, default 4, number of slave input ports (>=2, need not be a power of two).
REQ-002 SHALL have parameter DATA_W, default 32, payload width per port.
REQ-003 SHALL have parameter SEL_DEPTH, default 8, maximum outstanding select tokens (>=1).
REQ-004 SHALL have port i_clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port i_reset  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port i_sel_valid  input  1  select token from the upstream splitter, one per dispatched transaction.
REQ-007 SHALL have port o_sel_ready  output  1  token accepted when i_sel_valid & o_sel_ready.
REQ-008 SHALL have port i_slave_valid  input  PORTS_N  per-port result valid.
REQ-009 SHALL have port o_slave_ready  output  PORTS_N  per-port result ready.
REQ-010 SHALL have port i_slave_data  input  PORTS_N*DATA_W  port k payload in bits [k*DATA_W +: DATA_W].
REQ-011 SHALL have port o_master_valid  output  1  merged result valid.
REQ-012 SHALL have port i_master_ready  input  1  downstream ready.
REQ-013 SHALL have port o_master_data  output  DATA_W  merged payload.
REQ-014 SHALL have port o_pending  output  $clog2(SEL_DEPTH+1)  current token count.

Function
REQ-015 SHALL keep token counter r_cnt (0..SEL_DEPTH); o_sel_ready = (r_cnt < SEL_DEPTH), combinational from r_cnt only; o_pending = r_cnt.
REQ-016 SHALL keep read pointer r_rd (0..PORTS_N-1) selecting the port whose result is consumed next; sequence 0,1,..,PORTS_N-1,0 (explicit wrap, not modulo-2^n).
REQ-017 SHALL define slot_free = !o_master_valid | i_master_ready.
REQ-018 SHALL drive o_slave_ready[k] = (r_rd == k) & (r_cnt != 0) & slot_free; all other ports 0; never dependent on i_slave_valid.
REQ-019 SHALL define take = i_slave_valid[r_rd] & o_slave_ready[r_rd]; on take, r_rd advances by one with wrap.
REQ-020 SHALL update r_cnt: +1 on token push only, -1 on take only, unchanged when both or neither occur.
REQ-021 SHALL NOT bypass: a token pushed in cycle N enables a take no earlier than cycle N+1.
REQ-022 SHALL register output: on take, o_master_valid <= 1 and o_master_data <= payload of port r_rd; else if i_master_ready, o_master_valid <= 0; latency slave-fire to o_master_valid = 1 cycle.
REQ-023 SHALL hold o_master_valid and o_master_data stable while o_master_valid & !i_master_ready.
REQ-024 SHALL sustain one result per cycle when tokens present, port r_rd valid and i_master_ready high.
REQ-025 SHALL ignore i_slave_valid on non-selected ports (no reordering, no skipping).
REQ-026 SHALL, when r_cnt == SEL_DEPTH and a take occurs, still refuse the push that cycle (o_sel_ready from registered r_cnt).

Reset
REQ-027 SHALL, on i_clk edge with i_reset high, set r_cnt=0, r_rd=0, o_master_valid=0, o_master_data=0, discarding in-flight tokens and the output slot.
REQ-028 SHALL force o_sel_ready=0 and o_slave_ready=0 while i_reset is high; o_sel_ready=1 the first cycle after reset release.

Structure
REQ-029 SHALL take the default PORTS_N and a next-index-with-wrap function from a shared package rr_pkg, also used by the splitter, so both sides step identically.
REQ-030 SHALL implement the output register as one sub-module merger_out_slice (valid/ready, DATA_W, one entry); counter and pointer stay in merger.

Verification
REQ-031 SHALL cover: reset, then 4 tokens, ports 0..3 valid with data 0xA0..0xA3, ready=1 -> outputs 0xA0,0xA1,0xA2,0xA3 on consecutive cycles, r_rd back to 0.
REQ-032 SHALL cover: port 2 valid before port 1 with 3 tokens -> port 2 stalled until port 1 fires; output order 0,1,2.
REQ-033 SHALL cover: SEL_DEPTH=8 tokens pushed, no slave valid -> o_sel_ready=0, o_pending=8; simultaneous push+take at full -> push refused, o_pending=7.
REQ-034 SHALL cover: i_master_ready=0 for 5 cycles with result held -> o_master_data stable, o_slave_ready all 0 until ready returns.
REQ-035 SHALL cover: i_reset pulsed with 3 tokens pending and o_master_valid=1 -> next cycle o_pending=0, o_master_valid=0, r_rd=0.
REQ-036 SHALL cover: PORTS_N=3, 7 transactions -> port order 0,1,2,0,1,2,0.

Source files
------------

// File: rtl/rr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rr_pkg
// Description : Round-robin helpers shared by the splitter and the merger so
//               both sides step through ports in exactly the same order.
// Revision    : 1.0  initial release
// ============================================================================
package rr_pkg;

    localparam int PORTS_N_DEFAULT = 4;

    // Next port index with explicit wrap, so non-power-of-two port counts work.
    function automatic int rr_next(input int idx, input int n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/merger_if.sv
`default_nettype none
// ============================================================================
// Module      : merger_if
// Description : Token, per-port result and merged-output handshakes of merger.
// Revision    : 1.0  initial release
// ============================================================================
interface merger_if #(
    parameter int PORTS_N   = rr_pkg::PORTS_N_DEFAULT,
    parameter int DATA_W    = 32,
    parameter int SEL_DEPTH = 8
);
    localparam int CNT_W = $clog2(SEL_DEPTH + 1);

    logic                        i_sel_valid;
    logic                        o_sel_ready;
    logic [PORTS_N-1:0]          i_slave_valid;
    logic [PORTS_N-1:0]          o_slave_ready;
    logic [PORTS_N*DATA_W-1:0]   i_slave_data;
    logic                        o_master_valid;
    logic                        i_master_ready;
    logic [DATA_W-1:0]           o_master_data;
    logic [CNT_W-1:0]            o_pending;

    modport slave (
        input  i_sel_valid, i_slave_valid, i_slave_data, i_master_ready,
        output o_sel_ready, o_slave_ready, o_master_valid, o_master_data, o_pending
    );

    modport master (
        output i_sel_valid, i_slave_valid, i_slave_data, i_master_ready,
        input  o_sel_ready, o_slave_ready, o_master_valid, o_master_data, o_pending
    );

endinterface
`default_nettype wire

// File: rtl/merger_out_slice.sv
`default_nettype none
// ============================================================================
// Module      : merger_out_slice
// Description : One-entry registered valid/ready output stage.
// Revision    : 1.0  initial release
// ============================================================================
module merger_out_slice #(
    parameter int DATA_W = 32
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              in_valid,
    input  wire logic [DATA_W-1:0] in_data,
    output logic                   in_ready,
    output logic                   out_valid,
    input  wire logic              out_ready,
    output logic [DATA_W-1:0]      out_data
);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;

    // Caller only loads when in_ready is high, so a load never drops a result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (in_valid) begin
            r_valid <= 1'b1;
            r_data  <= in_data;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign in_ready  = !r_valid || out_ready;
    assign out_valid = r_valid;
    assign out_data  = r_data;

endmodule
`default_nettype wire

// File: rtl/merger.sv
`default_nettype none
// ============================================================================
// Module      : merger
// Description : Re-orders per-port results into dispatch order using select
//               tokens and a round-robin read pointer.
// Revision    : 1.0  initial release
// ============================================================================
module merger
    import rr_pkg::*;
#(
    parameter int PORTS_N   = PORTS_N_DEFAULT,
    parameter int DATA_W    = 32,
    parameter int SEL_DEPTH = 8
) (
    input  wire logic  i_clk,
    input  wire logic  i_reset,
    merger_if.slave    bus
);

    localparam int RD_W  = (PORTS_N > 1) ? $clog2(PORTS_N) : 1;
    localparam int CNT_W = $clog2(SEL_DEPTH + 1);
    localparam logic [CNT_W-1:0] c_depth = CNT_W'(SEL_DEPTH);

    logic [CNT_W-1:0]   r_cnt;
    logic [RD_W-1:0]    r_rd;
    logic               w_push;
    logic               w_take;
    logic               w_slot_free;
    logic               w_sel_ready;
    logic [PORTS_N-1:0] w_slave_ready;
    logic [DATA_W-1:0]  w_payload;

    assign w_sel_ready = (r_cnt < c_depth) && !i_reset;
    assign w_push      = bus.i_sel_valid && w_sel_ready;

    // Registered r_cnt gates the slave side, so a fresh token cannot be consumed
    // in the cycle it arrives.
    always_comb begin
        w_slave_ready = '0;
        if (!i_reset && (r_cnt != '0) && w_slot_free) begin
            w_slave_ready[r_rd] = 1'b1;
        end
    end

    assign w_take    = bus.i_slave_valid[r_rd] && w_slave_ready[r_rd];
    assign w_payload = bus.i_slave_data[int'(r_rd) * DATA_W +: DATA_W];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt <= '0;
            r_rd  <= '0;
        end else begin
            if (w_push && !w_take) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end else if (!w_push && w_take) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
            if (w_take) begin
                r_rd <= RD_W'(rr_next(int'(r_rd), PORTS_N));
            end
        end
    end

    merger_out_slice #(
        .DATA_W (DATA_W)
    ) u_out (
        .clk       (i_clk),
        .rst       (i_reset),
        .in_valid  (w_take),
        .in_data   (w_payload),
        .in_ready  (w_slot_free),
        .out_valid (bus.o_master_valid),
        .out_ready (bus.i_master_ready),
        .out_data  (bus.o_master_data)
    );

    assign bus.o_sel_ready   = w_sel_ready;
    assign bus.o_slave_ready = w_slave_ready;
    assign bus.o_pending     = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_merger.sv
`default_nettype none
// ============================================================================
// Module      : tb_merger
// Description : Directed self-checking bench for merger (4-port and 3-port).
// Revision    : 1.0  initial release
// ============================================================================
module tb_merger;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    merger_if #(.PORTS_N(4), .DATA_W(32), .SEL_DEPTH(8)) bus4 ();
    merger_if #(.PORTS_N(3), .DATA_W(32), .SEL_DEPTH(8)) bus3 ();

    merger #(.PORTS_N(4), .DATA_W(32), .SEL_DEPTH(8)) u_dut4 (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus4)
    );

    merger #(.PORTS_N(3), .DATA_W(32), .SEL_DEPTH(8)) u_dut3 (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus3)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_data4(input logic [31:0] base);
        for (int k = 0; k < 4; k++) bus4.i_slave_data[k*32 +: 32] = base + 32'(k);
    endtask

    task automatic test_reset;
        tick;
        tick;
        n_tests++;
        if (bus4.o_sel_ready !== 1'b0 || bus4.o_slave_ready !== 4'b0000) begin
            $display("FAIL reset_ready_gating: sel_ready=%b slave_ready=%b, expected 0/0000",
                     bus4.o_sel_ready, bus4.o_slave_ready);
            n_fail++;
        end
        n_tests++;
        if (bus4.o_pending !== 4'd0 || bus4.o_master_valid !== 1'b0 || bus4.o_master_data !== 32'h0) begin
            $display("FAIL reset_state: pending=%0d valid=%b data=%h, expected 0/0/0",
                     bus4.o_pending, bus4.o_master_valid, bus4.o_master_data);
            n_fail++;
        end
        rst = 1'b0;
        #1;
        n_tests++;
        if (bus4.o_sel_ready !== 1'b1 || bus3.o_sel_ready !== 1'b1) begin
            $display("FAIL reset_release_sel_ready: got %b/%b, expected 1/1",
                     bus4.o_sel_ready, bus3.o_sel_ready);
            n_fail++;
        end
    endtask

    task automatic test_sequential;
        logic [31:0] exp;
        bus4.i_master_ready = 1'b1;
        bus4.i_slave_valid  = 4'hF;
        set_data4(32'hA0);
        for (int i = 1; i <= 6; i++) begin
            bus4.i_sel_valid = (i <= 4);
            tick;
            if (i >= 2 && i <= 5) begin
                exp = 32'hA0 + 32'(i - 2);
                n_tests++;
                if (bus4.o_master_valid !== 1'b1 || bus4.o_master_data !== exp) begin
                    $display("FAIL seq_out[%0d]: valid=%b data=%h, expected 1/%h",
                             i, bus4.o_master_valid, bus4.o_master_data, exp);
                    n_fail++;
                end
            end
        end
        bus4.i_sel_valid = 1'b0;
        n_tests++;
        if (bus4.o_master_valid !== 1'b0 || u_dut4.r_rd !== 2'd0 || bus4.o_pending !== 4'd0) begin
            $display("FAIL seq_end: valid=%b r_rd=%0d pending=%0d, expected 0/0/0",
                     bus4.o_master_valid, u_dut4.r_rd, bus4.o_pending);
            n_fail++;
        end
        bus4.i_slave_valid = 4'h0;
    endtask

    task automatic test_order;
        set_data4(32'hB0);
        bus4.i_sel_valid = 1'b1;
        repeat (3) tick;
        bus4.i_sel_valid   = 1'b0;
        bus4.i_slave_valid = 4'b0101;
        tick;
        n_tests++;
        if (bus4.o_master_valid !== 1'b1 || bus4.o_master_data !== 32'hB0) begin
            $display("FAIL order_first: valid=%b data=%h, expected 1/b0",
                     bus4.o_master_valid, bus4.o_master_data);
            n_fail++;
        end
        n_tests++;
        if (bus4.o_slave_ready !== 4'b0010) begin
            $display("FAIL order_sel_port1: slave_ready=%b, expected 0010", bus4.o_slave_ready);
            n_fail++;
        end
        tick;
        n_tests++;
        if (bus4.o_master_valid !== 1'b0 || bus4.o_pending !== 4'd2) begin
            $display("FAIL order_port2_stalled: valid=%b pending=%0d, expected 0/2",
                     bus4.o_master_valid, bus4.o_pending);
            n_fail++;
        end
        bus4.i_slave_valid = 4'b0111;
        tick;
        n_tests++;
        if (bus4.o_master_valid !== 1'b1 || bus4.o_master_data !== 32'hB1) begin
            $display("FAIL order_second: valid=%b data=%h, expected 1/b1",
                     bus4.o_master_valid, bus4.o_master_data);
            n_fail++;
        end
        tick;
        n_tests++;
        if (bus4.o_master_valid !== 1'b1 || bus4.o_master_data !== 32'hB2) begin
            $display("FAIL order_third: valid=%b data=%h, expected 1/b2",
                     bus4.o_master_valid, bus4.o_master_data);
            n_fail++;
        end
        bus4.i_slave_valid = 4'h0;
        tick;
    endtask

    task automatic test_full;
        logic [31:0] exp;
        set_data4(32'hC0);
        bus4.i_sel_valid = 1'b1;
        repeat (8) tick;
        n_tests++;
        if (bus4.o_sel_ready !== 1'b0 || bus4.o_pending !== 4'd8) begin
            $display("FAIL full_state: sel_ready=%b pending=%0d, expected 0/8",
                     bus4.o_sel_ready, bus4.o_pending);
            n_fail++;
        end
        bus4.i_slave_valid = 4'hF;
        tick;
        n_tests++;
        if (bus4.o_pending !== 4'd7 || bus4.o_master_data !== 32'hC3 || bus4.o_sel_ready !== 1'b1) begin
            $display("FAIL full_push_take: pending=%0d data=%h sel_ready=%b, expected 7/c3/1",
                     bus4.o_pending, bus4.o_master_data, bus4.o_sel_ready);
            n_fail++;
        end
        bus4.i_sel_valid = 1'b0;
        for (int j = 0; j < 7; j++) begin
            tick;
            exp = 32'hC0 + 32'(j % 4);
            n_tests++;
            if (bus4.o_master_valid !== 1'b1 || bus4.o_master_data !== exp) begin
                $display("FAIL full_drain[%0d]: valid=%b data=%h, expected 1/%h",
                         j, bus4.o_master_valid, bus4.o_master_data, exp);
                n_fail++;
            end
        end
        bus4.i_slave_valid = 4'h0;
        tick;
        n_tests++;
        if (bus4.o_pending !== 4'd0) begin
            $display("FAIL full_drained: pending=%0d, expected 0", bus4.o_pending);
            n_fail++;
        end
    endtask

    task automatic test_backpressure;
        set_data4(32'hD0);
        bus4.i_master_ready = 1'b0;
        bus4.i_slave_valid  = 4'hF;
        bus4.i_sel_valid    = 1'b1;
        tick;
        tick;
        bus4.i_sel_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick;
            n_tests++;
            if (bus4.o_master_valid !== 1'b1 || bus4.o_master_data !== 32'hD3 ||
                bus4.o_slave_ready !== 4'b0000) begin
                $display("FAIL bp_hold[%0d]: valid=%b data=%h slave_ready=%b, expected 1/d3/0000",
                         i, bus4.o_master_valid, bus4.o_master_data, bus4.o_slave_ready);
                n_fail++;
            end
        end
        bus4.i_master_ready = 1'b1;
        #1;
        n_tests++;
        if (bus4.o_slave_ready !== 4'b0001) begin
            $display("FAIL bp_release_ready: slave_ready=%b, expected 0001", bus4.o_slave_ready);
            n_fail++;
        end
        tick;
        n_tests++;
        if (bus4.o_master_valid !== 1'b1 || bus4.o_master_data !== 32'hD0) begin
            $display("FAIL bp_after: valid=%b data=%h, expected 1/d0",
                     bus4.o_master_valid, bus4.o_master_data);
            n_fail++;
        end
        bus4.i_slave_valid = 4'h0;
        tick;
    endtask

    task automatic test_reset_inflight;
        bus4.i_master_ready = 1'b0;
        bus4.i_sel_valid    = 1'b1;
        repeat (4) tick;
        bus4.i_sel_valid   = 1'b0;
        set_data4(32'hE0);
        bus4.i_slave_valid = 4'hF;
        tick;
        n_tests++;
        if (bus4.o_master_valid !== 1'b1 || bus4.o_pending !== 4'd3 || bus4.o_master_data !== 32'hE1) begin
            $display("FAIL rst_pre: valid=%b pending=%0d data=%h, expected 1/3/e1",
                     bus4.o_master_valid, bus4.o_pending, bus4.o_master_data);
            n_fail++;
        end
        rst = 1'b1;
        bus4.i_master_ready = 1'b1;
        #1;
        n_tests++;
        if (bus4.o_sel_ready !== 1'b0 || bus4.o_slave_ready !== 4'b0000) begin
            $display("FAIL rst_gating: sel_ready=%b slave_ready=%b, expected 0/0000",
                     bus4.o_sel_ready, bus4.o_slave_ready);
            n_fail++;
        end
        tick;
        rst = 1'b0;
        #1;
        n_tests++;
        if (bus4.o_pending !== 4'd0 || bus4.o_master_valid !== 1'b0 || u_dut4.r_rd !== 2'd0 ||
            bus4.o_sel_ready !== 1'b1) begin
            $display("FAIL rst_after: pending=%0d valid=%b r_rd=%0d sel_ready=%b, expected 0/0/0/1",
                     bus4.o_pending, bus4.o_master_valid, u_dut4.r_rd, bus4.o_sel_ready);
            n_fail++;
        end
        bus4.i_slave_valid = 4'h0;
    endtask

    task automatic test_three_ports;
        logic [31:0] exp;
        for (int k = 0; k < 3; k++) bus3.i_slave_data[k*32 +: 32] = 32'hF0 + 32'(k);
        bus3.i_master_ready = 1'b1;
        bus3.i_slave_valid  = 3'b111;
        for (int i = 1; i <= 9; i++) begin
            bus3.i_sel_valid = (i <= 7);
            tick;
            if (i >= 2 && i <= 8) begin
                exp = 32'hF0 + 32'((i - 2) % 3);
                n_tests++;
                if (bus3.o_master_valid !== 1'b1 || bus3.o_master_data !== exp) begin
                    $display("FAIL p3_out[%0d]: valid=%b data=%h, expected 1/%h",
                             i, bus3.o_master_valid, bus3.o_master_data, exp);
                    n_fail++;
                end
            end
        end
        bus3.i_sel_valid = 1'b0;
        n_tests++;
        if (bus3.o_master_valid !== 1'b0 || u_dut3.r_rd !== 2'd1 || bus3.o_pending !== 4'd0) begin
            $display("FAIL p3_end: valid=%b r_rd=%0d pending=%0d, expected 0/1/0",
                     bus3.o_master_valid, u_dut3.r_rd, bus3.o_pending);
            n_fail++;
        end
    endtask

    initial begin
        bus4.i_sel_valid = 1'b0; bus4.i_slave_valid = '0; bus4.i_slave_data = '0; bus4.i_master_ready = 1'b1;
        bus3.i_sel_valid = 1'b0; bus3.i_slave_valid = '0; bus3.i_slave_data = '0; bus3.i_master_ready = 1'b1;
        test_reset;
        test_sequential;
        test_order;
        test_full;
        test_backpressure;
        test_reset_inflight;
        test_three_ports;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
